// File: rtl/barrel_shift_left_pipe_32.sv
// 32-bit left barrel shifter (rotate-left or logical shift-left with zero fill)
// built as a two-stage registered pipeline with valid/ready on both sides.
// Stage 1 resolves the coarse byte-granular part of the amount (bits [4:3]);
// stage 2 resolves the fine bit-granular part (bits [2:0]).
module barrel_shift_left_pipe_32 #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] i_a,
  input  logic [4:0]       num_left_i,
  input  logic             rot_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] o_y,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int AMT_W  = $clog2(WIDTH);
  // SPLIT is fixed at 2: the coarse stage handles shifts of 0/8/16/24.
  localparam int FINE_W = AMT_W - SPLIT;

  logic [WIDTH-1:0]  s1_data;
  logic [FINE_W-1:0] s1_amt;
  logic              s1_rot;
  logic              s1_vld;
  logic              adv1;
  logic              adv2;
  logic [AMT_W-1:0]  coarse_amt;
  logic [AMT_W-1:0]  fine_amt;

  // Shift the operand into the upper half of a double-width word; the lower
  // half carries either a copy (rotate wraps MSBs into LSBs) or zeros.
  function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] a,
                                           input logic [AMT_W-1:0] n,
                                           input logic             rot);
    logic [2*WIDTH-1:0] ext;
    ext = {a, (rot ? a : {WIDTH{1'b0}})} << n;
    return ext[2*WIDTH-1:WIDTH];
  endfunction

  // Stall logic: an empty stage always accepts, so bubbles collapse.
  always_comb begin
    adv2       = !valid_o || ready_i;
    adv1       = !s1_vld || adv2;
    ready_o    = adv1;
    coarse_amt = {num_left_i[AMT_W-1 -: SPLIT], {FINE_W{1'b0}}};
    fine_amt   = {{SPLIT{1'b0}}, s1_amt};
  end

  // Stage 1: coarse shift and capture of the residual amount and mode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_data <= '0;
      s1_amt  <= '0;
      s1_rot  <= 1'b0;
      s1_vld  <= 1'b0;
    end else if (adv1) begin
      s1_data <= shl(i_a, coarse_amt, rot_i);
      s1_amt  <= num_left_i[FINE_W-1:0];
      s1_rot  <= rot_i;
      s1_vld  <= valid_i;
    end
  end

  // Stage 2: fine shift into the output register; holds while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      o_y     <= '0;
      valid_o <= 1'b0;
    end else if (adv2) begin
      o_y     <= shl(s1_data, fine_amt, s1_rot);
      valid_o <= s1_vld;
    end
  end

endmodule

// File: tb/tb_barrel_shift_left_pipe_32.sv
// Bench for barrel_shift_left_pipe_32: directed vectors with hand-computed
// results plus an in-order scoreboard fed by a bit-level reference model.
module tb_barrel_shift_left_pipe_32;

  logic        clk_i;
  logic        rst_ni;
  logic [31:0] i_a;
  logic [4:0]  num_left_i;
  logic        rot_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] o_y;
  logic        valid_o;
  logic        ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic        hold_prev = 1'b0;
  logic [31:0] hold_y    = '0;

  barrel_shift_left_pipe_32 dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_a        (i_a),
    .num_left_i (num_left_i),
    .rot_i      (rot_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .o_y        (o_y),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit-level reference: each source bit i lands at position i+n.
  function automatic logic [31:0] model_rol(input logic [31:0] a, input int n, input logic rot);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (rot) r[(i + n) % 32] = a[i];
      else if (i + n < 32) r[i + n] = a[i];
    end
    return r;
  endfunction

  // Model of the companion right-rotate shifter.
  function automatic logic [31:0] model_ror(input logic [31:0] a, input int m);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = a[(i + m) % 32];
    return r;
  endfunction

  // Advance to just after the next rising edge; all stimulus changes here.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard and hold-stability monitor, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      exp_q.delete();
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", {31'b0, valid_o}, 32'd1);
        check("hold_data", o_y, hold_y);
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) check("sb_extra_beat", 32'(exp_q.size()), 32'd1);
        else check("sb_data", o_y, exp_q.pop_front());
      end
      if (valid_i && ready_o) exp_q.push_back(model_rol(i_a, int'(num_left_i), rot_i));
      hold_prev <= valid_o && !ready_i;
      hold_y    <= o_y;
    end
  end

  // Single beat through an idle pipeline; checks the result one cycle after acceptance.
  task automatic beat(input logic [31:0] a, input int n, input logic r,
                      input logic [31:0] exp, input string tag);
    i_a = a; num_left_i = 5'(n); rot_i = r; valid_i = 1'b1; ready_i = 1'b1;
    @(negedge clk_i);
    check({tag, "_ready"}, {31'b0, ready_o}, 32'd1);
    step();
    valid_i = 1'b0;
    step();
    @(negedge clk_i);
    check({tag, "_valid"}, {31'b0, valid_o}, 32'd1);
    check(tag, o_y, exp);
    step();
  endtask

  initial begin
    int acc;
    int cyc;

    rst_ni = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
    i_a = 32'hDEAD_BEEF; num_left_i = 5'd3; rot_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_valid_o", {31'b0, valid_o}, 32'd0);
    check("rst_o_y", o_y, 32'h0);
    check("rst_ready_o", {31'b0, ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1; valid_i = 1'b0;
    step();

    beat(32'h8000_0001, 1, 1'b1, 32'h0000_0003, "first_rot1");
    beat(32'hF000_000F, 4, 1'b1, 32'h0000_00FF, "rot4");
    beat(32'hF000_000F, 4, 1'b0, 32'h0000_00F0, "shl4");
    beat(32'h0000_0003, 31, 1'b0, 32'h8000_0000, "shl31");
    beat(32'h1234_5678, 0, 1'b0, 32'h1234_5678, "shl0");
    beat(32'h1234_5678, 0, 1'b1, 32'h1234_5678, "rot0");

    // Back-to-back stream of every rotate amount at full throughput.
    for (int k = 0; k < 34; k++) begin
      ready_i = 1'b1;
      if (k < 32) begin
        i_a = 32'h1234_5678; num_left_i = 5'(k); rot_i = 1'b1; valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      @(negedge clk_i);
      if (k >= 2) begin
        check("b2b_valid", {31'b0, valid_o}, 32'd1);
        check("b2b_vs_ror", o_y, model_ror(32'h1234_5678, (32 - (k - 2)) % 32));
        if (k - 2 == 8)  check("b2b_n8", o_y, 32'h3456_7812);
        if (k - 2 == 16) check("b2b_n16", o_y, 32'h5678_1234);
      end
      step();
    end

    // Backpressure: fill both stages, stall five cycles, then release.
    ready_i = 1'b0;
    i_a = 32'h0000_00FF; num_left_i = 5'd4; rot_i = 1'b0; valid_i = 1'b1;
    @(negedge clk_i);
    check("bp_ready_a", {31'b0, ready_o}, 32'd1);
    step();
    i_a = 32'hA5A5_A5A5; num_left_i = 5'd1; rot_i = 1'b1;
    @(negedge clk_i);
    check("bp_ready_b", {31'b0, ready_o}, 32'd1);
    step();
    i_a = 32'h0000_0003; num_left_i = 5'd31; rot_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check("bp_full_ready", {31'b0, ready_o}, 32'd0);
      check("bp_stall_valid", {31'b0, valid_o}, 32'd1);
      check("bp_stall_data", o_y, 32'h0000_0FF0);
      step();
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_release_ready", {31'b0, ready_o}, 32'd1);
    step();
    valid_i = 1'b0;
    @(negedge clk_i);
    check("bp_drain_b_valid", {31'b0, valid_o}, 32'd1);
    check("bp_drain_b", o_y, 32'h4B4B_4B4B);
    step();
    @(negedge clk_i);
    check("bp_drain_c_valid", {31'b0, valid_o}, 32'd1);
    check("bp_drain_c", o_y, 32'h8000_0001);
    step();
    @(negedge clk_i);
    check("bp_empty", {31'b0, valid_o}, 32'd0);
    step();

    // Random stress against the scoreboard.
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      valid_i    = ($urandom_range(0, 99) < 70);
      ready_i    = ($urandom_range(0, 99) < 70);
      i_a        = $urandom;
      num_left_i = 5'($urandom_range(0, 31));
      rot_i      = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      if (valid_i && ready_o) acc++;
      step();
      cyc++;
    end
    check("stress_beats", 32'(acc), 32'd10000);
    valid_i = 1'b0; ready_i = 1'b1;
    repeat (3) step();
    @(negedge clk_i);
    check("stress_drained", 32'(exp_q.size()), 32'd0);
    step();

    // Mid-stream asynchronous reset with two beats in flight.
    ready_i = 1'b0;
    i_a = 32'h0F0F_0F0F; num_left_i = 5'd12; rot_i = 1'b1; valid_i = 1'b1;
    step();
    i_a = 32'h7777_0000; num_left_i = 5'd5; rot_i = 1'b0;
    step();
    valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid_o", {31'b0, valid_o}, 32'd0);
    check("mid_rst_o_y", o_y, 32'h0);
    check("mid_rst_ready_o", {31'b0, ready_o}, 32'd1);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    step();
    ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      check("post_rst_no_ghost", {31'b0, valid_o}, 32'd0);
      step();
    end
    beat(32'hC000_0001, 2, 1'b1, 32'h0000_0007, "post_rst_beat");
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
